fp32_addsub_arbiter: RTL

Two-port arbiter and sequencer that shares one multi-cycle FP32 add/sub datapath between two requesters. It accepts operand pairs over valid/ready, grants round-robin, and issues a one-cycle start pulse to the datapath. It then waits for the datapath's done, with a watchdog, and returns the result to the granted requester over a held valid/ready response. It sits between the integer pipeline's FP issue ports and the FP32 add/sub unit.

---
 rtl/fp32_pkg.sv | 22 ++
 rtl/rr_arbiter_2.sv | 18 +
 rtl/fp32_addsub_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared types and constants for the FP32 add/sub front-end.
//   FP32_QNAN    : canonical quiet NaN returned when the datapath never answers
//   ctrl_state_e : sequencer state encoding
//   fp32_req_t   : one operand pair plus operation mode (1 = A-B)
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
  } fp32_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
//   valid[1:0] : request lines
//   rr         : preferred requester when both are valid
//   grant[1:0] : one-hot grant, zero when nobody requests
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fp32_addsub_arbiter.sv
// Shares one multi-cycle FP32 add/sub datapath between two requesters.
// Accepts an operand pair over valid/ready, pulses the datapath start, waits
// for done under a watchdog and returns the result over a held response.
//   i_clk, i_rst              : clock, async active-high reset
//   i_req_valid/o_req_ready   : per-requester request handshake
//   i_req_a/i_req_b/i_req_mode: per-requester operands and mode
//   o_dp_*                    : datapath start pulse and latched operands
//   i_dp_done/i_dp_result     : datapath completion
//   o_rsp_valid/i_rsp_ready   : per-requester response handshake
//   o_rsp_result/o_rsp_err    : shared result, err = watchdog abort
//   o_busy                    : sequencer not idle
//
// state | meaning
// IDLE  | arbitrate, accept one request
// ISSUE | start pulse to datapath, clear watchdog
// WAIT  | wait for done or watchdog expiry
// RESP  | hold response until granted requester accepts
module fp32_addsub_arbiter
  import fp32_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [1:0][31:0] i_req_a,
  input  logic [1:0][31:0] i_req_b,
  input  logic [1:0]      i_req_mode,
  output logic            o_dp_start,
  output logic [31:0]     o_dp_a,
  output logic [31:0]     o_dp_b,
  output logic            o_dp_mode,
  input  logic            i_dp_done,
  input  logic [31:0]     i_dp_result,
  output logic [1:0]      o_rsp_valid,
  input  logic [1:0]      i_rsp_ready,
  output logic [31:0]     o_rsp_result,
  output logic            o_rsp_err,
  output logic            o_busy
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  ctrl_state_e state, state_next;
  logic        rr;
  logic        gnt_idx;
  logic [1:0]  grant;
  fp32_req_t   op;
  logic [7:0]  wd_cnt;
  logic [31:0] result;
  logic        err;

  rr_arbiter_2 u_arb (
    .valid (i_req_valid),
    .rr    (rr),
    .grant (grant)
  );

  always_comb begin
    state_next  = state;
    o_req_ready = 2'b00;
    o_dp_start  = 1'b0;
    o_rsp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (|grant) begin
          o_req_ready = grant;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        o_dp_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (i_dp_done || (wd_cnt == WD_LAST)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = gnt_idx ? 2'b10 : 2'b01;
        if (i_rsp_ready[gnt_idx]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      rr      <= 1'b0;
      gnt_idx <= 1'b0;
      op      <= '0;
      wd_cnt  <= 8'd0;
      result  <= 32'd0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (|grant) begin
            gnt_idx <= grant[1];
            op      <= grant[1] ? '{a: i_req_a[1], b: i_req_b[1], mode: i_req_mode[1]}
                                : '{a: i_req_a[0], b: i_req_b[0], mode: i_req_mode[0]};
          end
        end
        ISSUE: wd_cnt <= 8'd0;
        WAIT: begin
          // done has priority over a watchdog expiry in the same cycle
          if (i_dp_done) begin
            result <= i_dp_result;
            err    <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            result <= FP32_QNAN;
            err    <= 1'b1;
          end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready[gnt_idx]) begin
            rr <= ~gnt_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dp_a       = op.a;
  assign o_dp_b       = op.b;
  assign o_dp_mode    = op.mode;
  assign o_rsp_result = result;
  assign o_rsp_err    = err;
  assign o_busy       = (state != IDLE);

endmodule
